// File: rtl/vga_term_pkg.sv
// rtl/vga_term_pkg.sv - shared constants and state type for the VGA text-console writer
package vga_term_pkg;

   localparam int ROWS_DEF = 30;
   localparam int COLS_DEF = 70;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_TAB   = 8'h09;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_ESC   = 8'h1B;
   localparam logic [7:0] CH_SPACE = 8'h20;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLR_LINE = 2'd1,
      CLR_SCR  = 2'd2
`ifdef VGA_TERM_ESC_EN
      ,ESC     = 2'd3
`endif
   } term_state_t;

endpackage

// File: rtl/vga_term_writer.sv
// rtl/vga_term_writer.sv - byte-stream text console driving the character memory write port (optional colour escape: VGA_TERM_ESC_EN)
module vga_term_writer
   import vga_term_pkg::*;
#(
   parameter int         ROWS   = ROWS_DEF,
   parameter int         COLS   = COLS_DEF,
   parameter logic [2:0] DEF_FG = 3'b111,
   parameter logic [2:0] DEF_BG = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_char,
   output logic       we,
   output logic [4:0] wr_addr,
   output logic [6:0] wc_addr,
   output logic [7:0] w_ascii,
   output logic [2:0] w_fg_color,
   output logic [2:0] w_bg_color,
   output logic [4:0] cur_row,
   output logic [6:0] cur_col,
   output logic       busy
);

   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [7:0] COLS_8   = 8'(COLS);

   term_state_t state, state_n;
   logic [4:0]  row_n, sw_row, sw_row_n, wr_n;
   logic [6:0]  col_n, sw_col, sw_col_n, wc_n;
   logic [7:0]  asc_n, tab;
   logic        we_n, sw_done, sw_done_n, nl, accept;
   logic [2:0]  fg, bg, fg_n, bg_n;

`ifdef VGA_TERM_ESC_EN
   assign in_ready = (state == IDLE) || (state == ESC);
`else
   assign in_ready = (state == IDLE);
   assign fg = DEF_FG;
   assign bg = DEF_BG;
`endif
   assign busy   = (state == CLR_LINE) || (state == CLR_SCR);
   assign accept = in_valid && in_ready;

   // State, cursor, sweep counters and registered write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_row    <= '0;
         cur_col    <= '0;
         sw_row     <= '0;
         sw_col     <= '0;
         sw_done    <= 1'b0;
         we         <= 1'b0;
         wr_addr    <= '0;
         wc_addr    <= '0;
         w_ascii    <= 8'h00;
         w_fg_color <= DEF_FG;
         w_bg_color <= DEF_BG;
      end else begin
         state      <= state_n;
         cur_row    <= row_n;
         cur_col    <= col_n;
         sw_row     <= sw_row_n;
         sw_col     <= sw_col_n;
         sw_done    <= sw_done_n;
         we         <= we_n;
         wr_addr    <= wr_n;
         wc_addr    <= wc_n;
         w_ascii    <= asc_n;
         w_fg_color <= fg_n;
         w_bg_color <= bg_n;
      end
   end

`ifdef VGA_TERM_ESC_EN
   // Colour registers, loaded by the byte following an escape
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fg <= DEF_FG;
         bg <= DEF_BG;
      end else begin
         fg <= fg_n;
         bg <= bg_n;
      end
   end
`endif

   // Character interpretation, cursor movement and clear sweeps
   always_comb begin
      state_n   = state;
      row_n     = cur_row;
      col_n     = cur_col;
      sw_row_n  = sw_row;
      sw_col_n  = sw_col;
      sw_done_n = sw_done;
      we_n      = 1'b0;
      wr_n      = wr_addr;
      wc_n      = wc_addr;
      asc_n     = w_ascii;
      fg_n      = fg;
      bg_n      = bg;
      nl        = 1'b0;
      tab       = {1'b0, cur_col | 7'd7} + 8'd1;
      case (state)
         IDLE: begin
            if (accept) begin
               if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                  we_n  = 1'b1;
                  wr_n  = cur_row;
                  wc_n  = cur_col;
                  asc_n = in_char;
                  if (cur_col == LAST_COL) begin
                     col_n = '0;
                     nl    = 1'b1;
                  end else begin
                     col_n = cur_col + 7'd1;
                  end
               end else begin
                  case (in_char)
                     CH_LF: begin
                        col_n = '0;
                        nl    = 1'b1;
                     end
                     CH_CR: col_n = '0;
                     CH_BS: begin
                        if (cur_col != '0) begin
                           col_n = cur_col - 7'd1;
                        end else if (cur_row != '0) begin
                           row_n = cur_row - 5'd1;
                           col_n = LAST_COL;
                        end
                        we_n  = 1'b1;
                        wr_n  = row_n;
                        wc_n  = col_n;
                        asc_n = CH_SPACE;
                     end
                     CH_TAB: begin
                        if (tab >= COLS_8) begin
                           col_n = '0;
                           nl    = 1'b1;
                        end else begin
                           col_n = tab[6:0];
                        end
                     end
                     CH_FF: begin
                        row_n     = '0;
                        col_n     = '0;
                        state_n   = CLR_SCR;
                        sw_row_n  = '0;
                        sw_col_n  = '0;
                        sw_done_n = 1'b0;
                     end
`ifdef VGA_TERM_ESC_EN
                     CH_ESC: state_n = ESC;
`endif
                     default: ;
                  endcase
               end
               // Wrapping off the bottom row lands on row 0, which must be blanked
               if (nl) begin
                  if (cur_row < LAST_ROW) begin
                     row_n = cur_row + 5'd1;
                  end else begin
                     row_n     = '0;
                     state_n   = CLR_LINE;
                     sw_row_n  = '0;
                     sw_col_n  = '0;
                     sw_done_n = 1'b0;
                  end
               end
            end
         end
         CLR_LINE, CLR_SCR: begin
            // sw_done holds the state for the cycle showing the final write
            if (sw_done) begin
               state_n = IDLE;
            end else begin
               we_n  = 1'b1;
               wr_n  = sw_row;
               wc_n  = sw_col;
               asc_n = CH_SPACE;
               if (sw_col == LAST_COL) begin
                  sw_col_n = '0;
                  if (state == CLR_LINE || sw_row == LAST_ROW) begin
                     sw_done_n = 1'b1;
                  end else begin
                     sw_row_n = sw_row + 5'd1;
                  end
               end else begin
                  sw_col_n = sw_col + 7'd1;
               end
            end
         end
`ifdef VGA_TERM_ESC_EN
         ESC: begin
            if (accept) begin
               fg_n    = in_char[2:0];
               bg_n    = in_char[5:3];
               state_n = IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

endmodule
